// File: rtl/imp_pkg.sv
// rtl/imp_pkg.sv - shared types and status bit positions for the IMP transfer sequencer
package imp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } imp_seq_state_e;

  localparam int IMP_SIZE_W = 8;

  // Bit positions of the sticky status word as seen by the register file.
  localparam int STS_RD_DONE  = 0;
  localparam int STS_WR_DONE  = 1;
  localparam int STS_RD_TMO   = 2;
  localparam int STS_WR_TMO   = 3;
  localparam int STS_KICK_OVR = 4;
  localparam int STS_W        = 5;

endpackage

// File: rtl/imp_ch_seq.sv
// rtl/imp_ch_seq.sv - one channel job FSM with beat counter and inactivity watchdog
module imp_ch_seq
  import imp_pkg::*;
#(
  parameter int TMO_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kick,
  input  logic [IMP_SIZE_W-1:0] hsize,
  input  logic [IMP_SIZE_W-1:0] vsize,
  input  logic                  beat,
  input  logic                  abort,
  input  logic                  sts_clr,
  output logic                  st,
  output logic                  busy,
  output logic                  done,
  output logic                  tmo,
  output logic [CNT_WIDTH-1:0]  cnt,
  output logic                  kick_ign
);

  // Expiry is taken on the edge that would make the watchdog all-ones.
  localparam logic [TMO_WIDTH-1:0] WDOG_LAST = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

  imp_seq_state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0]         target_q, target_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [TMO_WIDTH-1:0]         wdog_q, wdog_d;
  logic                         done_q, done_d;
  logic                         tmo_q, tmo_d;
  logic                         done_set, tmo_set;
  logic [2*IMP_SIZE_W-1:0]      prod;

  assign prod = hsize * vsize;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    done_set = 1'b0;
    tmo_set  = 1'b0;
    kick_ign = kick & (state_q != IDLE);
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (kick) begin
            target_d = CNT_WIDTH'(prod);
            cnt_d    = '0;
            wdog_d   = '0;
            if (prod == '0) done_set = 1'b1;
            else            state_d  = RUN;
          end
        end
        RUN: begin
          if (beat) begin
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            wdog_d = '0;
            if (cnt_q == target_q - CNT_WIDTH'(1)) begin
              state_d  = IDLE;
              done_set = 1'b1;
            end
          end else begin
            wdog_d = wdog_q + TMO_WIDTH'(1);
            if (wdog_q == WDOG_LAST) begin
              state_d = ERR;
              tmo_set = 1'b1;
            end
          end
        end
        ERR: begin
          if (sts_clr) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // A set in the same cycle as a clear must survive.
    done_d = (done_q & ~sts_clr) | done_set;
    tmo_d  = (tmo_q & ~sts_clr) | tmo_set;
  end

  assign st   = (state_q == RUN);
  assign busy = (state_q == RUN);
  assign done = done_q;
  assign tmo  = tmo_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/imp_xfer_seq.sv
// rtl/imp_xfer_seq.sv - read/write job sequencer for the IMP AXI-Lite master
module imp_xfer_seq
  import imp_pkg::*;
#(
  parameter int TMO_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_kick,
  input  logic                  wr_kick,
  input  logic [IMP_SIZE_W-1:0] rd_hsize,
  input  logic [IMP_SIZE_W-1:0] rd_vsize,
  input  logic [IMP_SIZE_W-1:0] wr_hsize,
  input  logic [IMP_SIZE_W-1:0] wr_vsize,
  input  logic                  rd_beat,
  input  logic                  wr_beat,
  input  logic                  abort,
  input  logic                  sts_clr,
  input  logic                  irq_en,
  output logic                  rd_st,
  output logic                  wr_st,
  output logic                  rd_busy,
  output logic                  wr_busy,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic                  rd_tmo,
  output logic                  wr_tmo,
  output logic                  kick_ovr,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic                  irq
);

  logic             rd_kick_ign, wr_kick_ign;
  logic             kick_ovr_q;
  logic             irq_q;
  logic [STS_W-1:0] sts;

  imp_ch_seq #(.TMO_WIDTH(TMO_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_rd (
    .clk      (clk),
    .rst      (rst),
    .kick     (rd_kick),
    .hsize    (rd_hsize),
    .vsize    (rd_vsize),
    .beat     (rd_beat),
    .abort    (abort),
    .sts_clr  (sts_clr),
    .st       (rd_st),
    .busy     (rd_busy),
    .done     (rd_done),
    .tmo      (rd_tmo),
    .cnt      (rd_cnt),
    .kick_ign (rd_kick_ign)
  );

  imp_ch_seq #(.TMO_WIDTH(TMO_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_wr (
    .clk      (clk),
    .rst      (rst),
    .kick     (wr_kick),
    .hsize    (wr_hsize),
    .vsize    (wr_vsize),
    .beat     (wr_beat),
    .abort    (abort),
    .sts_clr  (sts_clr),
    .st       (wr_st),
    .busy     (wr_busy),
    .done     (wr_done),
    .tmo      (wr_tmo),
    .cnt      (wr_cnt),
    .kick_ign (wr_kick_ign)
  );

  always_comb begin
    sts               = '0;
    sts[STS_RD_DONE]  = rd_done;
    sts[STS_WR_DONE]  = wr_done;
    sts[STS_RD_TMO]   = rd_tmo;
    sts[STS_WR_TMO]   = wr_tmo;
    sts[STS_KICK_OVR] = kick_ovr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kick_ovr_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      kick_ovr_q <= (kick_ovr_q & ~sts_clr) | rd_kick_ign | wr_kick_ign;
      irq_q      <= irq_en & (|sts);
    end
  end

  assign kick_ovr = kick_ovr_q;
  assign irq      = irq_q;

endmodule
